// File: rtl/weight_bank_pkg.sv
// Shared types and helpers for the weight bank router.
// Mode and FSM state encodings plus the per-mode drain length.
package weight_bank_pkg;

    typedef enum logic {
        MODE_CONV      = 1'b0,
        MODE_TRANSCONV = 1'b1
    } mode_e;

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } state_e;

    // Cycles until the last read of a mode has fully left the datapath.
    function automatic int drain_len(mode_e m, int num_ch);
        return (m == MODE_CONV) ? num_ch : 1;
    endfunction

endpackage

// File: rtl/weight_skew_line.sv
// DELAY-stage data+valid shift register for systolic skew.
// DELAY=0 degenerates to a plain wire.
module weight_skew_line #(
    parameter int DW    = 16,
    parameter int DELAY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          in_valid,
    output logic [DW-1:0] dout,
    output logic          out_valid
);

    if (DELAY == 0) begin : g_wire
        logic unused;
        assign unused    = clk ^ rst_n;
        assign dout      = din;
        assign out_valid = in_valid;
    end else begin : g_pipe
        logic [DW-1:0]    d_q [DELAY];
        logic [DELAY-1:0] v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= '0;
                for (int k = 0; k < DELAY; k++) d_q[k] <= '0;
            end else begin
                d_q[0] <= din;
                v_q[0] <= in_valid;
                for (int k = 1; k < DELAY; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign dout      = d_q[DELAY-1];
        assign out_valid = v_q[DELAY-1];
    end

endmodule

// File: rtl/weight_bank_router.sv
// Weight BRAM bank with conv/transconv read muxing, conv skew
// and drain-protected mode switching.
module weight_bank_router
    import weight_bank_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int DW         = 16,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            w_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] w_addr_wr_flat,
    input  logic [NUM_CH*DW-1:0]         w_din_flat,
    input  logic [NUM_CH-1:0]            re_conv,
    input  logic [NUM_CH-1:0]            re_transconv,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_rd_conv_flat,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_rd_transconv_flat,
    input  logic                         start_conv,
    input  logic                         start_transconv,
    output logic [NUM_CH*DW-1:0]         weight_out_flat,
    output logic [NUM_CH-1:0]            weight_valid,
    output logic                         mode,
    output logic                         busy,
    output logic                         mode_err
);

    localparam int AW = ADDR_WIDTH;
    localparam int CW = $clog2(NUM_CH + 1);

    state_e                 state;
    mode_e                  mode_q;
    mode_e                  pending;
    logic [CW-1:0]          cnt;
    logic                   busy_q;
    logic                   err_q;
    logic                   req_any;
    mode_e                  req_mode;
    logic [NUM_CH-1:0]      re_eff;
    logic [NUM_CH*AW-1:0]   addr_eff;
    logic [NUM_CH-1:0]      rd_valid;
    mode_e                  rd_mode;

    assign req_any  = start_conv | start_transconv;
    assign req_mode = start_transconv ? MODE_TRANSCONV : MODE_CONV;

    always_comb begin
        re_eff   = '0;
        addr_eff = addr_rd_conv_flat;
        if (mode_q == MODE_TRANSCONV) addr_eff = addr_rd_transconv_flat;
        if (!busy_q) begin
            re_eff = (mode_q == MODE_TRANSCONV) ? re_transconv : re_conv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACTIVE;
            mode_q  <= MODE_CONV;
            pending <= MODE_CONV;
            cnt     <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                ACTIVE: begin
                    if (start_conv && start_transconv) begin
                        err_q <= 1'b1;
                    end else if (req_any && req_mode != mode_q) begin
                        state   <= DRAIN;
                        pending <= req_mode;
                        cnt     <= CW'(drain_len(mode_q, NUM_CH));
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (req_any) err_q <= 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        mode_q <= pending;
                        state  <= ACTIVE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    // Tag each BRAM read with the mode it was issued in, so the
    // output path stays correct across the mode flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_mode  <= MODE_CONV;
        end else begin
            rd_valid <= re_eff;
            rd_mode  <= mode_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_data;
        logic [DW-1:0] sk_d;
        logic          sk_v;
        logic          dir_v;

        always_ff @(posedge clk) begin
            if (w_we[i]) mem[w_addr_wr_flat[i*AW +: AW]] <= w_din_flat[i*DW +: DW];
            if (re_eff[i]) rd_data <= mem[addr_eff[i*AW +: AW]];
        end

        weight_skew_line #(
            .DW    (DW),
            .DELAY (i)
        ) u_skew (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (rd_data),
            .in_valid  (rd_valid[i] && rd_mode == MODE_CONV),
            .dout      (sk_d),
            .out_valid (sk_v)
        );

        assign dir_v           = rd_valid[i] && rd_mode == MODE_TRANSCONV;
        assign weight_valid[i] = sk_v | dir_v;
        assign weight_out_flat[i*DW +: DW] =
            sk_v ? sk_d : (dir_v ? rd_data : '0);
    end

    assign mode     = mode_q;
    assign busy     = busy_q;
    assign mode_err = err_q;

endmodule

// File: doc/weight_bank_router.md
# weight_bank_router

Parametrised weight-memory front end for the convolution / transposed-convolution PE array. It holds NUM_CH independent weight BRAMs and muxes the conv and transconv read ports onto them. In conv mode it applies a built-in per-channel systolic skew to the read data; in transconv mode it passes read data straight through. Mode changes are registered and drain-protected: in-flight reads of one mode never emerge in the other, and every output word carries a per-channel valid.

## Interface
- NUM_CH, 16, number of weight channels/BRAMs
- DW, 16, weight word width (signed)
- DEPTH, 2048, words per BRAM
- ADDR_WIDTH, $clog2(DEPTH), BRAM address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- w_we  in  NUM_CH  per-channel write enable
- w_addr_wr_flat  in  NUM_CH*ADDR_WIDTH  write addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- w_din_flat  in  NUM_CH*DW  write data
- re_conv / re_transconv  in  NUM_CH each  per-channel read enables, per mode
- addr_rd_conv_flat / addr_rd_transconv_flat  in  NUM_CH*ADDR_WIDTH each  read addresses, per mode
- start_conv / start_transconv  in  1 each  mode request pulses
- weight_out_flat  out  NUM_CH*DW  weights to PE array
- weight_valid  out  NUM_CH  per-channel output valid
- mode  out  1  0 = conv, 1 = transconv (registered)
- busy  out  1  drain in progress, reads gated
- mode_err  out  1  sticky illegal-request flag

## Operation
- Writes go straight to the BRAMs in every state and mode. Read-during-write to the same address returns the old data (read-first).
- The effective read port is selected by the mode register: re_*/addr_* of the current mode. The other mode's port is ignored.
- While busy=1, all read enables are forced to 0.
- Conv mode: channel i data and valid are delayed i extra cycles (channel 0 has none).
- Transconv mode: channel data and valid are passed with no extra delay.
- weight_out for a channel is 0 whenever that channel's weight_valid is 0.
- FSM states:
  - ACTIVE: reads pass; mode requests are accepted here.
  - DRAIN: reads gated; a down-counter runs.
- Request handling in ACTIVE:
  - A request for a different mode → DRAIN with cnt = L(current mode), pending = requested mode.
  - A request for the current mode is a no-op.
  - start_conv and start_transconv both high → mode_err set, no mode change.
- DRAIN: cnt decrements each cycle. At the edge where cnt==1: mode ← pending, state ← ACTIVE.
- Any request arriving in DRAIN is ignored and sets mode_err.
- L(conv) = NUM_CH (1 BRAM cycle + NUM_CH-1 skew). L(transconv) = 1. The counter is $clog2(NUM_CH+1) bits.
- Reset values: mode=0 (conv), state ACTIVE, busy=0, mode_err=0, weight_valid=0, weight_out=0, all skew lines cleared. Reset mid-drain abandons the pending switch; mode returns to conv.

## Timing
- re at edge t gives BRAM data at t+1.
  - transconv: channel i valid at t+1.
  - conv: channel i valid at t+1+i.
- Accepted request at edge t: busy=1 from t+1 for exactly L cycles. The new mode is visible and busy=0 after that; a read can be issued on the first cycle busy=0.
- The last conv read issued before the request still emerges fully skewed before the mode flips.
- mode_err stays high until reset.

## Structure
- Package weight_bank_pkg holds:
  - mode_e: MODE_CONV=0, MODE_TRANSCONV=1
  - state_e: ACTIVE, DRAIN
  - function drain_len(mode, NUM_CH)
- Sub-module weight_skew_line #(DW, DELAY): a DELAY-stage data+valid shift register; DELAY=0 is a wire. One instance per channel, generated with DELAY=i.
- BRAMs use the team's simple dual-port, read-first, 1-cycle-latency BRAM primitive, one per channel.

## Test plan
All cases use NUM_CH=4, DW=16, DEPTH=64.
- Reset → mode=0, busy=0, mode_err=0, weight_valid=0000, weight_out=0.
- Write ch i addr 5 = 0x0100+i. In conv mode pulse re_conv=1111 at addr 5 at edge t → ch i valid exactly at t+1+i with 0x0100+i, 0 elsewhere.
- start_transconv at t → busy high t+1..t+4, mode=1 at t+5. re_transconv=1111 at t+5 → all four channels valid at t+6. re_transconv asserted during busy produces no valid.
- In transconv, write addr 7 = 0xBEEF and read addr 7 in the same cycle (old value 0x1111) → 0x1111 returned; next read returns 0xBEEF.
- start_conv and start_transconv high together → mode_err=1, mode unchanged, busy stays 0. A request during DRAIN → mode_err=1, original switch completes.
- rst_n asserted at cycle 2 of a conv→transconv drain → immediate clear, mode=0, busy=0, valid=0000.
